// File: rtl/write_ingress_ctrl.sv
// write_ingress_ctrl: write-side front end of the async FIFO (skid buffer + fill level)
// Ports:
//   clk, rst_n           write-domain clock, asynchronous active-low reset
//   in_valid/in_data     producer beat; in_ready (registered) completes the handshake
//   full                 registered full flag from the write pointer; stalls winc
//   wptr, wq2_rptr       gray write pointer and synced gray read pointer
//   winc, wdata          write strobe and head-of-buffer data to pointer/memory
//   wlevel, almost_full  registered conservative occupancy and advisory threshold flag
module write_ingress_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 6,
   parameter int AFULL_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  full,
   input  logic [ADDR_WIDTH:0]   wptr,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic                  winc,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  almost_full
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] AF_LVL = PW'(DEPTH - AFULL_THRESH);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t state, state_next;
   logic [DATA_WIDTH-1:0] head, skid, head_next, skid_next;
   logic [PW-1:0] wlevel_next;
   logic acc;
   function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
      return b;
   endfunction
   assign acc = in_valid & in_ready;
   // winc is combinational from state so an async reset kills the strobe immediately
   assign winc = (state != EMPTY) & ~full;
   assign wdata = head;
   // Modulo subtraction handles pointer wrap; the lagging read pointer makes this an over-estimate
   assign wlevel_next = g2b(wptr) - g2b(wq2_rptr);
   always_comb begin
      state_next = state;
      head_next = head;
      skid_next = skid;
      unique case (state)
         EMPTY: if (acc) begin
            state_next = ONE;
            head_next = in_data;
         end
         ONE: if (acc & winc) head_next = in_data;
         else if (acc) begin
            state_next = TWO;
            skid_next = in_data;
         end else if (winc) state_next = EMPTY;
         TWO: if (winc) begin
            state_next = ONE;
            head_next = skid;
         end
         default: state_next = EMPTY;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         head <= '0;
         skid <= '0;
         in_ready <= 1'b0;
         wlevel <= '0;
         almost_full <= 1'b0;
      end else begin
         state <= state_next;
         head <= head_next;
         skid <= skid_next;
         in_ready <= state_next != TWO;
         wlevel <= wlevel_next;
         almost_full <= wlevel_next >= AF_LVL;
      end
   end
endmodule
